chef_sprite_ctrl: RTL and testbench
===================================

// Module: chef_sprite_ctrl
// PURPOSE
//  Downstream consumer of the chef position (ChefX/ChefY, 10-bit, game px).
//  Derives per-frame motion state and facing, and runs the walk/climb animation counter.
//  Maps each VGA pixel (DrawX/DrawY) to a chef sprite-ROM address plus an in-sprite flag.
//  Feeds the colour mapper and sprite ROM.
// PARAMETERS
//  SPRITE_W  16  sprite width, px (power of 2)
//  SPRITE_H  16  sprite height, px (power of 2)
//  N_WALK    3   animation frames per walk/climb cycle
//  ANIM_DIV  8   frame ticks per animation step
//  ROM_AW    12  sprite_addr width
// PORTS
//  Clk          in   1       system clock
//  Reset        in   1       synchronous, active-high
//  frame_clk    in   1       vsync-rate level signal; sampled in the Clk domain
//  ChefX        in   10      chef sprite top-left X, from chef position logic
//  ChefY        in   10      chef sprite top-left Y
//  DrawX        in   10      current pixel X
//  DrawY        in   10      current pixel Y
//  is_chef      out  1       pixel lies inside the sprite box
//  sprite_addr  out  ROM_AW  ROM word address; 0 when is_chef=0
//  flip_h       out  1       1 = facing left
//  chef_state   out  3       chef_state_t encoding (debug/HUD)
// BEHAVIOUR
//  Tick: frame_clk -> 2-flop sync -> rising-edge detect -> 1-Clk pulse.
//   tick asserts 3 Clk after the frame_clk rising edge.
//  On tick, compare ChefX/ChefY with prev_x/prev_y latched at the previous tick:
//   x dec -> WALK_L; x inc -> WALK_R; else y dec -> CLIMB_U; y inc -> CLIMB_D; else IDLE.
//   X has priority when both change. prev_x/prev_y update on every tick.
//  primed flag: the first tick after Reset only latches prev and sets primed; state stays IDLE.
//  Facing: WALK_L sets flip_h=1; WALK_R clears it. IDLE/CLIMB hold it.
//  Anim (on tick):
//   - new state == old state and not IDLE: div++.
//   - div==ANIM_DIV-1: div wraps to 0 and frame=(frame+1)%N_WALK.
//   - state change or IDLE: div=0, frame=0.
//  Tile index:
//   - IDLE = 0.
//   - WALK_* = 1+frame.
//   - CLIMB_* = 1+N_WALK+frame.
//   - base = tile*SPRITE_W*SPRITE_H.
//  Pixel pipeline, 2 Clk latency DrawX/DrawY -> outputs, one pixel per Clk:
//   S1: relx=DrawX-ChefX, rely=DrawY-ChefY as 11-bit signed.
//       inside = relx,rely >= 0 && relx<SPRITE_W && rely<SPRITE_H.
//   S2: col = flip_h ? SPRITE_W-1-relx : relx.
//       sprite_addr = base + rely*SPRITE_W + col (truncated to ROM_AW).
//       is_chef = inside.
//  S2 samples flip_h, state and frame live (a tick mid-line affects later pixels only).
//  Negative rel values are outside; no wrap-around at X=0 or Y=0.
//  Reset (any cycle):
//   - outputs: is_chef=0, sprite_addr=0, flip_h=0, chef_state=IDLE.
//   - internal: div=0, frame=0, primed=0, prev=0, pipeline flushed.
//   - reset wins over a same-cycle tick.
// CONFIGURATION
//  CHEF_BBOX_EN defined:
//   - extra output bbox_edge (1 bit), aligned with is_chef.
//   - bbox_edge=1 when inside and relx in {0,SPRITE_W-1} or rely in {0,SPRITE_H-1}.
//   - reset value 0.
//  CHEF_BBOX_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  chef_pkg:
//   - chef_state_t enum: IDLE=0, WALK_L=1, WALK_R=2, CLIMB_U=3, CLIMB_D=4.
//   - tile base constants, SPRITE_W/H defaults.
//  Sub-module frame_tick_sync: synchronizer + rising-edge detect. Ports: Clk, Reset, frame_clk, tick.
// TESTING
//  1 Reset, one tick, ChefX=96,ChefY=141 held -> chef_state=IDLE, flip_h=0, no spurious walk.
//  2 Decrement ChefX by 1 per tick for 9 ticks -> WALK_L, flip_h=1.
//    frame steps 0->1 on the 8th same-state tick; tile 2 -> sprite_addr base 512.
//  3 After 2, ChefY+1 per tick -> CLIMB_D, frame=0, base=(1+3)*256=1024; flip_h stays 1.
//  4 ChefX=96,ChefY=141, sweep DrawX 95..112 on DrawY=141 -> is_chef=0 at 95 and 112, 1 for 96..111.
//    2-Clk latency; facing right -> addr=base+0..15; flip_h=1 -> base+15..0.
//  5 ChefX=0,DrawX=1023 -> is_chef=0 (no wrap).
//    Reset asserted mid-line -> next Clk is_chef=0, sprite_addr=0, chef_state=IDLE.
//  6 CHEF_BBOX_EN defined: pixels (96,141),(111,150) -> bbox_edge=1; (100,145) -> 0.

Source files
------------

// File: rtl/chef_pkg.sv
// Shared types and constants for the chef sprite controller.
// The optional bounding-box edge output is enabled with the CHEF_BBOX_EN macro.
package chef_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WALK_L  = 3'd1,
        WALK_R  = 3'd2,
        CLIMB_U = 3'd3,
        CLIMB_D = 3'd4
    } chef_state_t;

    localparam int CHEF_SPRITE_W = 16;
    localparam int CHEF_SPRITE_H = 16;
    localparam int CHEF_N_WALK   = 3;
    localparam int CHEF_ANIM_DIV = 8;
    localparam int CHEF_ROM_AW   = 12;

    localparam int TILE_IDLE  = 0;
    localparam int TILE_WALK0 = 1;

    // Tile layout in the ROM: idle, then N walk frames, then N climb frames.
    function automatic int tile_index(chef_state_t st, int frame, int n_walk);
        case (st)
            WALK_L, WALK_R:   tile_index = TILE_WALK0 + frame;
            CLIMB_U, CLIMB_D: tile_index = TILE_WALK0 + n_walk + frame;
            default:          tile_index = TILE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/chef_sprite_ctrl_frame_tick_sync.sv
// Synchronises the vsync-rate frame_clk into the Clk domain and emits a
// registered one-Clk pulse three Clk edges after its rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync1_q, sync2_q, sync3_q, tick_q;

    // Two-flop synchroniser, edge history flop and registered rising-edge pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            tick_q  <= sync2_q & ~sync3_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/chef_sprite_ctrl.sv
// Chef motion/facing/animation tracking and pixel-to-sprite-ROM address mapping.
// Define CHEF_BBOX_EN to add the bbox_edge output.
import chef_pkg::*;

module chef_sprite_ctrl #(
    parameter int SPRITE_W = CHEF_SPRITE_W,
    parameter int SPRITE_H = CHEF_SPRITE_H,
    parameter int N_WALK   = CHEF_N_WALK,
    parameter int ANIM_DIV = CHEF_ANIM_DIV,
    parameter int ROM_AW   = CHEF_ROM_AW
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        ChefX,
    input  logic [9:0]        ChefY,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              is_chef,
    output logic [ROM_AW-1:0] sprite_addr,
    output logic              flip_h,
    output logic [2:0]        chef_state
`ifdef CHEF_BBOX_EN
    ,
    output logic              bbox_edge
`endif
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FW = (N_WALK > 1) ? $clog2(N_WALK) : 1;

    logic        tick_s;
    chef_state_t state_q, state_d, motion_s;
    logic        flip_q, flip_d, primed_q, primed_d;
    logic [9:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] frame_q, frame_d;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick_s)
    );

    // Motion classification against the position latched at the previous tick; X wins.
    always_comb begin
        motion_s = IDLE;
        if (ChefX < prev_x_q) begin
            motion_s = WALK_L;
        end else if (ChefX > prev_x_q) begin
            motion_s = WALK_R;
        end else if (ChefY < prev_y_q) begin
            motion_s = CLIMB_U;
        end else if (ChefY > prev_y_q) begin
            motion_s = CLIMB_D;
        end else begin
            motion_s = IDLE;
        end
    end

    // Per-tick next state: motion, facing and animation divider/frame.
    always_comb begin
        state_d  = state_q;
        flip_d   = flip_q;
        primed_d = primed_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        div_d    = div_q;
        frame_d  = frame_q;
        if (tick_s) begin
            prev_x_d = ChefX;
            prev_y_d = ChefY;
            primed_d = 1'b1;
            if (primed_q) begin
                state_d = motion_s;
                case (motion_s)
                    WALK_L:  flip_d = 1'b1;
                    WALK_R:  flip_d = 1'b0;
                    default: flip_d = flip_q;
                endcase
                if ((motion_s == state_q) && (motion_s != IDLE)) begin
                    if (div_q == DW'(ANIM_DIV - 1)) begin
                        div_d   = '0;
                        frame_d = (frame_q == FW'(N_WALK - 1)) ? '0 : frame_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end else begin
                    div_d   = '0;
                    frame_d = '0;
                end
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Motion/animation state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            flip_q   <= 1'b0;
            primed_q <= 1'b0;
            prev_x_q <= 10'd0;
            prev_y_q <= 10'd0;
            div_q    <= '0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            flip_q   <= flip_d;
            primed_q <= primed_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            div_q    <= div_d;
            frame_q  <= frame_d;
        end
    end

    // S1: zero-extended differences, so bit 10 is the sign and nothing wraps at the screen edge.
    logic [10:0]   relx_s, rely_s;
    logic          inside_s, inside_q;
    logic [CW-1:0] relx_q;
    logic [RW-1:0] rely_q;

    assign relx_s   = {1'b0, DrawX} - {1'b0, ChefX};
    assign rely_s   = {1'b0, DrawY} - {1'b0, ChefY};
    assign inside_s = !relx_s[10] && !rely_s[10] &&
                      (relx_s[9:0] < 10'(SPRITE_W)) && (rely_s[9:0] < 10'(SPRITE_H));

`ifdef CHEF_BBOX_EN
    logic edge_s, edge_q, bbox_q;
    assign edge_s = inside_s &&
                    ((relx_s[CW-1:0] == CW'(0)) || (relx_s[CW-1:0] == CW'(SPRITE_W - 1)) ||
                     (rely_s[RW-1:0] == RW'(0)) || (rely_s[RW-1:0] == RW'(SPRITE_H - 1)));
`endif

    // S2 uses live facing/state, so a mid-line tick only affects later pixels.
    logic [CW-1:0]     col_s;
    logic [ROM_AW-1:0] base_s, addr_s;
    logic              is_chef_q;
    logic [ROM_AW-1:0] addr_q;

    assign col_s  = flip_q ? (CW'(SPRITE_W - 1) - relx_q) : relx_q;
    assign base_s = ROM_AW'(tile_index(state_q, int'(frame_q), N_WALK) * SPRITE_W * SPRITE_H);
    assign addr_s = base_s + ROM_AW'(rely_q) * ROM_AW'(SPRITE_W) + ROM_AW'(col_s);

    // Two-stage pixel pipeline registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            inside_q  <= 1'b0;
            relx_q    <= '0;
            rely_q    <= '0;
            is_chef_q <= 1'b0;
            addr_q    <= '0;
`ifdef CHEF_BBOX_EN
            edge_q    <= 1'b0;
            bbox_q    <= 1'b0;
`endif
        end else begin
            inside_q  <= inside_s;
            relx_q    <= relx_s[CW-1:0];
            rely_q    <= rely_s[RW-1:0];
            is_chef_q <= inside_q;
            addr_q    <= inside_q ? addr_s : '0;
`ifdef CHEF_BBOX_EN
            edge_q    <= edge_s;
            bbox_q    <= edge_q;
`endif
        end
    end

    assign is_chef     = is_chef_q;
    assign sprite_addr = addr_q;
    assign flip_h      = flip_q;
    assign chef_state  = state_q;
`ifdef CHEF_BBOX_EN
    assign bbox_edge   = bbox_q;
`endif

endmodule

// File: tb/tb_chef_sprite_ctrl.sv
// Self-checking bench for chef_sprite_ctrl: behavioural model compared every
// cycle plus hand-computed literal expectations. Honours CHEF_BBOX_EN.
module tb_chef_sprite_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  ChefX = 10'd96, ChefY = 10'd141, DrawX = 10'd0, DrawY = 10'd0;
    logic        is_chef, flip_h;
    logic [11:0] sprite_addr;
    logic [2:0]  chef_state;
`ifdef CHEF_BBOX_EN
    logic        bbox_edge;
`endif

    chef_sprite_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .ChefX       (ChefX),
        .ChefY       (ChefY),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .is_chef     (is_chef),
        .sprite_addr (sprite_addr),
        .flip_h      (flip_h),
        .chef_state  (chef_state)
`ifdef CHEF_BBOX_EN
        ,
        .bbox_edge   (bbox_edge)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state as small integers, animation via run length of same-state ticks.
    int m_state = 0, m_flip = 0, m_run = 0, m_primed = 0, m_px = 0, m_py = 0;
    int h_dx = 0, h_dy = 0, h_valid = 0;
    int e_is = 0, e_addr = 0, e_edge = 0;
    bit started = 1'b0;

    function automatic int m_tile();
        int fr;
        fr = (m_run / 8) % 3;
        if (m_state == 0) return 0;
        else if (m_state <= 2) return 1 + fr;
        else return 4 + fr;
    endfunction

    task automatic model_tick();
        int ns;
        if (m_primed != 0) begin
            if (int'(ChefX) < m_px) ns = 1;
            else if (int'(ChefX) > m_px) ns = 2;
            else if (int'(ChefY) < m_py) ns = 3;
            else if (int'(ChefY) > m_py) ns = 4;
            else ns = 0;
            if (ns == 1) m_flip = 1;
            else if (ns == 2) m_flip = 0;
            if (ns == m_state && ns != 0) m_run++;
            else m_run = 0;
            m_state = ns;
        end
        m_primed = 1;
        m_px = int'(ChefX);
        m_py = int'(ChefY);
    endtask

    // Expected pixel outputs at each active edge from the pixel seen one edge earlier.
    initial forever begin
        @(posedge Clk);
        if (Reset) begin
            e_is = 0; e_addr = 0; e_edge = 0; h_valid = 0;
            m_state = 0; m_flip = 0; m_run = 0; m_primed = 0; m_px = 0; m_py = 0;
            started = 1'b1;
        end else begin
            if (h_valid != 0 && h_dx >= 0 && h_dx < 16 && h_dy >= 0 && h_dy < 16) begin
                e_is   = 1;
                e_addr = (m_tile() * 256 + h_dy * 16 + ((m_flip != 0) ? 15 - h_dx : h_dx)) % 4096;
                e_edge = (h_dx == 0 || h_dx == 15 || h_dy == 0 || h_dy == 15) ? 1 : 0;
            end else begin
                e_is = 0; e_addr = 0; e_edge = 0;
            end
            h_dx = int'(DrawX) - int'(ChefX);
            h_dy = int'(DrawY) - int'(ChefY);
            h_valid = 1;
        end
    end

    // Compare process: all outputs against the model on every cycle after the first reset edge.
    initial forever begin
        @(negedge Clk);
        if (started) begin
            check("is_chef", is_chef, e_is);
            check("sprite_addr", sprite_addr, e_addr);
            check("chef_state", chef_state, m_state);
            check("flip_h", flip_h, m_flip);
`ifdef CHEF_BBOX_EN
            check("bbox_edge", bbox_edge, e_edge);
`endif
        end
    end

    task automatic do_tick();
        @(negedge Clk); frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1 model_tick();
        @(negedge Clk); frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic sweep(int y, int x0, int x1);
        DrawY = 10'(y);
        for (int x = x0; x <= x1; x++) begin
            @(negedge Clk); DrawX = 10'(x);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic pix_check(string nm, int x, int y, int exp_is, int exp_addr);
        @(negedge Clk); DrawX = 10'(x); DrawY = 10'(y);
        @(posedge Clk); @(posedge Clk); @(negedge Clk);
        check({nm, "_is"}, is_chef, exp_is);
        check({nm, "_addr"}, sprite_addr, exp_addr);
    endtask

    initial begin
        // Reset and priming with a nonzero held position.
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_state", chef_state, 0);
        check("rst_flip", flip_h, 0);
        check("rst_is", is_chef, 0);
        do_tick();
        check("prime_state", chef_state, 0);
        do_tick();
        check("held_state", chef_state, 0);
        pix_check("r96", 96, 141, 1, 0);
        pix_check("r111", 111, 141, 1, 15);
        pix_check("r112", 112, 141, 0, 0);
        pix_check("r95", 95, 141, 0, 0);
`ifdef CHEF_BBOX_EN
        pix_check("bb96", 96, 141, 1, 0);
        check("bb96_edge", bbox_edge, 1);
        pix_check("bb111", 111, 150, 1, 9 * 16 + 15);
        check("bb111_edge", bbox_edge, 1);
        pix_check("bb100", 100, 145, 1, 4 * 16 + 4);
        check("bb100_edge", bbox_edge, 0);
`endif
        sweep(141, 95, 112);

        // Walk left nine ticks: frame advances on the eighth repeat.
        for (int i = 0; i < 9; i++) begin
            ChefX = ChefX - 10'd1;
            do_tick();
        end
        check("walkl_state", chef_state, 1);
        check("walkl_flip", flip_h, 1);
        pix_check("wl0", 87, 141, 1, 527);
        pix_check("wl15", 102, 141, 1, 512);
        sweep(141, 86, 103);

        // Climb down, with a sweep running across the second tick.
        ChefY = ChefY + 10'd1;
        do_tick();
        ChefY = ChefY + 10'd1;
        fork
            do_tick();
            sweep(150, 80, 110);
        join
        check("climbd_state", chef_state, 4);
        check("climbd_flip", flip_h, 1);
        pix_check("cd0", 87, 143, 1, 1039);
        pix_check("cd7", 87, 150, 1, 1151);

        ChefX = ChefX + 10'd1;
        do_tick();
        check("walkr_state", chef_state, 2);
        check("walkr_flip", flip_h, 0);
        pix_check("wr0", 88, 143, 1, 256);

        ChefY = ChefY - 10'd1;
        do_tick();
        check("climbu_state", chef_state, 3);
        pix_check("cu0", 88, 142, 1, 1024);

        ChefX = ChefX - 10'd1;
        ChefY = ChefY + 10'd1;
        do_tick();
        check("xprio_state", chef_state, 1);
        check("xprio_flip", flip_h, 1);

        // Screen-edge no-wrap, then reset mid-line.
        ChefX = 10'd0;
        ChefY = 10'd0;
        pix_check("nowrap", 1023, 0, 0, 0);
        pix_check("origin", 0, 0, 1, 271);
        fork
            sweep(3, 0, 20);
            begin
                repeat (6) @(negedge Clk);
                Reset = 1'b1;
                @(negedge Clk);
                check("mrst_is", is_chef, 0);
                check("mrst_addr", sprite_addr, 0);
                check("mrst_state", chef_state, 0);
                check("mrst_flip", flip_h, 0);
                Reset = 1'b0;
            end
        join
        do_tick();
        do_tick();
        check("post_rst_state", chef_state, 0);
        pix_check("post_rst_pix", 2, 1, 1, 16 + 2);

        repeat (4) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
